// File: rtl/sva_pkg.sv
// Shared types and helpers for the multi-thread property checker.
package sva_pkg;

  // Controller states: wait for a tick, walk the slots, then try to spawn.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } ctrl_fsm_t;

  // Wait counters are max-sized; MAX_WAIT must stay below 2**WCNT_W.
  localparam int WCNT_W = 16;

  typedef struct packed {
    logic              active;
    logic [WCNT_W-1:0] wcnt;
  } sva_thread_t;

  // Slot-id width, never narrower than one bit.
  function automatic int slot_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sva_edge_sync.sv
// Two-flop sampler for the user clock with a single-cycle rising-edge tick.
module sva_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic grst,
  input  logic gclk,
  output logic tick
);

  logic d0_q, d1_q;

  // Sample gclk; the user reset forces both flops low so no edge is seen.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || grst) begin
      d0_q <= 1'b0;
      d1_q <= 1'b0;
    end else begin
      d0_q <= gclk;
      d1_q <= d0_q;
    end
  end

  assign tick = d0_q & ~d1_q;

endmodule

// File: rtl/sva_thread_engine.sv
// Multi-thread checker for a ##1 (!b)[*0:MAX_WAIT-1] ##1 b, one slot per cycle.
module sva_thread_engine
  import sva_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int MAX_WAIT    = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int IMPLICATION = 0
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                gclk,
  input  logic                                grst,
  input  logic                                a,
  input  logic                                b,
  output logic                                busy,
  output logic                                succ,
  output logic                                fail,
  output logic [slot_id_w(NUM_THREADS)-1:0]   evt_slot,
  output logic [CNT_WIDTH-1:0]                succ_cnt,
  output logic [CNT_WIDTH-1:0]                fail_cnt,
  output logic                                overflow,
  output logic                                tick_miss,
  output ctrl_fsm_t                           dbg_state
);

  localparam int               SW       = slot_id_w(NUM_THREADS);
  localparam logic [SW-1:0]    LAST_IDX = SW'(NUM_THREADS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  logic tick;

  ctrl_fsm_t      state_q, state_d;
  logic [SW-1:0]  idx_q, idx_d;
  logic           a_s_q, a_s_d, b_s_q, b_s_d;
  sva_thread_t    slots_q [NUM_THREADS];
  sva_thread_t    slots_d [NUM_THREADS];
  logic           succ_q, succ_d, fail_q, fail_d;
  logic [SW-1:0]  evt_slot_q, evt_slot_d;
  logic           overflow_q, overflow_d, tick_miss_q, tick_miss_d;
  logic [CNT_WIDTH-1:0] succ_cnt_q, succ_cnt_d, fail_cnt_q, fail_cnt_d;
  logic           free_found;
  logic [SW-1:0]  free_idx;

  sva_edge_sync u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .grst    (grst),
    .gclk    (gclk),
    .tick    (tick)
  );

  // Lowest-index free slot; slots released earlier in this scan are already free.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (!slots_q[i].active) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  // Controller next state, slot updates and event pulses.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_s_d       = a_s_q;
    b_s_d       = b_s_q;
    slots_d     = slots_q;
    succ_d      = 1'b0;
    fail_d      = 1'b0;
    evt_slot_d  = '0;
    overflow_d  = overflow_q;
    tick_miss_d = tick_miss_q;
    if (grst) begin
      state_d = IDLE;
      idx_d   = '0;
      for (int i = 0; i < NUM_THREADS; i++) slots_d[i] = '0;
    end else begin
      if (tick && (state_q != IDLE)) tick_miss_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            a_s_d   = a;
            b_s_d   = b;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (slots_q[idx_q].active) begin
            if (b_s_q) begin
              succ_d         = 1'b1;
              evt_slot_d     = idx_q;
              slots_d[idx_q] = '0;
            end else if (slots_q[idx_q].wcnt + WCNT_W'(1) == WAIT_LIM) begin
              fail_d         = 1'b1;
              evt_slot_d     = idx_q;
              slots_d[idx_q] = '0;
            end else begin
              slots_d[idx_q].wcnt = slots_q[idx_q].wcnt + WCNT_W'(1);
            end
          end
          if (idx_q == LAST_IDX) state_d = SPAWN;
          else                   idx_d   = idx_q + SW'(1);
        end
        SPAWN: begin
          if (a_s_q) begin
            if (free_found) begin
              slots_d[free_idx].active = 1'b1;
              slots_d[free_idx].wcnt   = '0;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (IMPLICATION == 0) begin
            fail_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating event counters, updated together with the pulse they count.
  always_comb begin
    succ_cnt_d = succ_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (succ_d && !(&succ_cnt_q)) succ_cnt_d = succ_cnt_q + CNT_WIDTH'(1);
    if (fail_d && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
  end

  // State, slot and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) slots_q[i] <= '0;
      succ_q      <= 1'b0;
      fail_q      <= 1'b0;
      evt_slot_q  <= '0;
      overflow_q  <= 1'b0;
      tick_miss_q <= 1'b0;
      succ_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_s_q       <= a_s_d;
      b_s_q       <= b_s_d;
      slots_q     <= slots_d;
      succ_q      <= succ_d;
      fail_q      <= fail_d;
      evt_slot_q  <= evt_slot_d;
      overflow_q  <= overflow_d;
      tick_miss_q <= tick_miss_d;
      succ_cnt_q  <= succ_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign succ      = succ_q;
  assign fail      = fail_q;
  assign evt_slot  = evt_slot_q;
  assign succ_cnt  = succ_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign overflow  = overflow_q;
  assign tick_miss = tick_miss_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sva_thread_engine.sv
// Directed bench: three engine configurations share one stimulus stream.
module tb_sva_thread_engine;
  import sva_pkg::*;

  logic sys_clk, sys_rst, gclk, grst, a, b;

  // dut0: defaults (N=4, MAX_WAIT=8, IMPLICATION=0)
  logic busy0, succ0, fail0, ovf0, miss0;
  logic [1:0] slot0;
  logic [15:0] sc0, fc0;
  ctrl_fsm_t st0;
  // dut1: IMPLICATION=1
  logic busy1, succ1, fail1, ovf1, miss1;
  logic [1:0] slot1;
  logic [15:0] sc1, fc1;
  ctrl_fsm_t st1;
  // dut2: NUM_THREADS=2
  logic busy2, succ2, fail2, ovf2, miss2;
  logic [0:0] slot2;
  logic [15:0] sc2, fc2;
  ctrl_fsm_t st2;

  sva_thread_engine dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gclk(gclk), .grst(grst), .a(a), .b(b),
    .busy(busy0), .succ(succ0), .fail(fail0), .evt_slot(slot0), .succ_cnt(sc0),
    .fail_cnt(fc0), .overflow(ovf0), .tick_miss(miss0), .dbg_state(st0)
  );

  sva_thread_engine #(.IMPLICATION(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gclk(gclk), .grst(grst), .a(a), .b(b),
    .busy(busy1), .succ(succ1), .fail(fail1), .evt_slot(slot1), .succ_cnt(sc1),
    .fail_cnt(fc1), .overflow(ovf1), .tick_miss(miss1), .dbg_state(st1)
  );

  sva_thread_engine #(.NUM_THREADS(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gclk(gclk), .grst(grst), .a(a), .b(b),
    .busy(busy2), .succ(succ2), .fail(fail2), .evt_slot(slot2), .succ_cnt(sc2),
    .fail_cnt(fc2), .overflow(ovf2), .tick_miss(miss2), .dbg_state(st2)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int rise_cyc = 0;
  int dbl      = 0;
  logic [31:0] obs0_q[$];
  logic [31:0] obs1_q[$];
  logic [31:0] obs2_q[$];
  logic [31:0] exp_q[$];

  // Event word: bit16 = fail, [15:8] = cycles from gclk rise, [7:0] = slot.
  function automatic logic [31:0] ev(input logic f, input int lat, input int slot);
    return {15'b0, f, lat[7:0], slot[7:0]};
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (succ0 || fail0) obs0_q.push_back(ev(fail0, cyc - rise_cyc, int'(slot0)));
      if (succ1 || fail1) obs1_q.push_back(ev(fail1, cyc - rise_cyc, int'(slot1)));
      if (succ2 || fail2) obs2_q.push_back(ev(fail2, cyc - rise_cyc, int'(slot2)));
      if ((succ0 && fail0) || (succ1 && fail1) || (succ2 && fail2)) dbl++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_events(input string tag, input int which);
    logic [31:0] got[$];
    case (which)
      0:       got = obs0_q;
      1:       got = obs1_q;
      default: got = obs2_q;
    endcase
    check_val({tag, "_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_val($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs0_q.delete();
    obs1_q.delete();
    obs2_q.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    gclk = 1'b0; grst = 1'b0; a = 1'b0; b = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear_obs();
  endtask

  // One gclk period: high for hi cycles, low for lo cycles; a/b held throughout.
  task automatic do_tick(input logic av, input logic bv, input int hi, input int lo);
    clear_obs();
    a = av; b = bv;
    gclk = 1'b1;
    rise_cyc = cyc;
    repeat (hi) @(posedge sys_clk);
    #1;
    gclk = 1'b0;
    repeat (lo) @(posedge sys_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1'b1; gclk = 1'b0; grst = 1'b0; a = 1'b0; b = 1'b0;
    do_reset();

    // Reset values
    check_val("rst_busy", busy0, 0);
    check_val("rst_succ", succ0, 0);
    check_val("rst_fail", fail0, 0);
    check_val("rst_slot", slot0, 0);
    check_val("rst_scnt", sc0, 0);
    check_val("rst_fcnt", fc0, 0);
    check_val("rst_ovf", ovf0, 0);
    check_val("rst_miss", miss0, 0);

    // a then b on the next tick: one success from slot 0
    do_tick(1'b1, 1'b0, 6, 6);
    check_events("basic_t1", 0);
    do_tick(1'b1, 1'b1, 6, 6);
    exp_q.push_back(ev(1'b0, 3, 0));
    check_events("basic_t2", 0);
    check_val("basic_scnt", sc0, 1);
    check_val("basic_fcnt", fc0, 0);

    // Two overlapping threads resolved on the same tick (slots 0 and 1)
    do_tick(1'b1, 1'b0, 6, 6);
    do_tick(1'b1, 1'b1, 6, 6);
    exp_q.push_back(ev(1'b0, 3, 0));
    exp_q.push_back(ev(1'b0, 4, 1));
    check_events("two_thr", 0);
    check_val("two_thr_scnt", sc0, 3);

    // Timeout: b low for 8 checks after a
    do_reset();
    do_tick(1'b1, 1'b0, 6, 6);
    for (int k = 2; k <= 8; k++) do_tick(1'b0, 1'b0, 6, 6);
    check_val("to_imp_pre_fcnt", fc1, 0);
    do_tick(1'b0, 1'b0, 6, 6);
    exp_q.push_back(ev(1'b1, 3, 0));
    check_events("to_imp_t9", 1);
    check_val("to_imp_fcnt", fc1, 1);
    exp_q.push_back(ev(1'b1, 3, 0));
    exp_q.push_back(ev(1'b1, 7, 0));
    check_events("to_def_t9", 0);
    check_val("to_def_fcnt", fc0, 9);
    check_val("to_n2_fcnt", fc2, 9);

    // !a ticks: failures without implication, nothing with it
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      do_tick(1'b0, 1'b0, 6, 6);
      exp_q.push_back(ev(1'b1, 7, 0));
      check_events($sformatf("noa_def_%0d", k), 0);
      check_events($sformatf("noa_imp_%0d", k), 1);
    end
    check_val("noa_def_fcnt", fc0, 3);
    check_val("noa_imp_fcnt", fc1, 0);
    check_val("noa_imp_scnt", sc1, 0);

    // Overflow with two slots, then both slots time out
    do_reset();
    do_tick(1'b1, 1'b0, 6, 6);
    do_tick(1'b1, 1'b0, 6, 6);
    check_val("ovf_t2", ovf2, 0);
    do_tick(1'b1, 1'b0, 6, 6);
    check_val("ovf_t3", ovf2, 1);
    check_val("ovf_n4_clear", ovf0, 0);
    for (int k = 4; k <= 8; k++) do_tick(1'b0, 1'b0, 6, 6);
    do_tick(1'b0, 1'b0, 6, 6);
    exp_q.push_back(ev(1'b1, 3, 0));
    exp_q.push_back(ev(1'b1, 5, 0));
    check_events("ovf_t9", 2);
    do_tick(1'b0, 1'b0, 6, 6);
    exp_q.push_back(ev(1'b1, 4, 1));
    exp_q.push_back(ev(1'b1, 5, 0));
    check_events("ovf_t10", 2);
    check_val("ovf_fcnt", fc2, 9);
    check_val("ovf_sticky", ovf2, 1);

    // gclk period shorter than the busy window: every other tick is dropped
    do_reset();
    for (int k = 0; k < 4; k++) do_tick(1'b0, 1'b0, 2, 2);
    repeat (10) @(posedge sys_clk);
    #1;
    check_val("miss_flag", miss0, 1);
    check_val("miss_fcnt", fc0, 2);
    check_val("miss_n2_fcnt", fc2, 4);
    do_tick(1'b0, 1'b0, 6, 6);
    check_val("miss_fcnt_after", fc0, 3);

    // grst mid-scan with two live threads; counters and sticky flags survive
    do_tick(1'b0, 1'b0, 6, 6);
    do_tick(1'b1, 1'b0, 6, 6);
    do_tick(1'b1, 1'b0, 6, 6);
    clear_obs();
    a = 1'b1; b = 1'b1;
    gclk = 1'b1;
    rise_cyc = cyc;
    repeat (2) @(posedge sys_clk);
    #1;
    grst = 1'b1;
    gclk = 1'b0;
    @(posedge sys_clk);
    #1;
    grst = 1'b0;
    check_val("grst_busy", busy0, 0);
    check_val("grst_state", st0, IDLE);
    repeat (10) @(posedge sys_clk);
    #1;
    check_events("grst_quiet", 0);
    check_val("grst_fcnt", fc0, 4);
    check_val("grst_scnt", sc0, 0);
    check_val("grst_miss", miss0, 1);
    do_tick(1'b0, 1'b1, 6, 6);
    exp_q.push_back(ev(1'b1, 7, 0));
    check_events("grst_after", 0);
    check_events("grst_after_imp", 1);
    check_val("grst_after_scnt", sc1, 0);

    // sys_rst clears everything
    do_reset();
    check_val("rst2_busy", busy0, 0);
    check_val("rst2_fcnt", fc0, 0);
    check_val("rst2_miss", miss0, 0);
    check_val("rst2_n2_fcnt", fc2, 0);
    check_val("rst2_n2_ovf", ovf2, 0);

    check_val("one_pulse", dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
